// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcodes, instruction field positions and state encodings for the
// pipeline sequencing controller.
package pipe_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [4:0] reg_idx_t;

    localparam opcode_t OP_LD = 6'b010100;
    localparam opcode_t OP_ST = 6'b010101;
    localparam opcode_t OP_BR = 6'b011100;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_STALL    = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic     v;
        opcode_t  op;
        reg_idx_t rd;
    } shadow_t;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Instruction/status inputs and enable outputs between the pipeline and its
// sequencing controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ins;
    logic             br_taken;
    logic             dm_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             pipe_en;
    logic             bubble;
    logic             flush;
    logic             dm_req;
    logic [1:0]       fsm_state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ins, br_taken, dm_ready,
        input  pc_en, ifid_en, pipe_en, bubble, flush, dm_req, fsm_state, stall_cnt
    );

    modport slave (
        input  ins, br_taken, dm_ready,
        output pc_en, ifid_en, pipe_en, bubble, flush, dm_req, fsm_state, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and the shadow of EX.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int IMM_BIT = 3
) (
    input  shadow_t  ex,
    input  opcode_t  id_op,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    output logic     lu_haz
);
    logic uses_rs2;

    // Immediate-form ALU ops carry an immediate in the rs2 field.
    assign uses_rs2 = (id_op == OP_ST) | (id_op == OP_BR) |
                      ((id_op != OP_LD) & ~id_op[IMM_BIT]);

    assign lu_haz = ex.v & (ex.op == OP_LD) &
                    ((ex.rd == id_rs1) | (uses_rs2 & (ex.rd == id_rs2)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: load-use stalls, branch
// squash, data-memory wait and the PC / pipeline-register enables.
//
// state    | meaning
// RUN      | normal issue last cycle
// STALL    | load-use bubble inserted last cycle
// FLUSH    | wrong-path squash in progress
// MEM_WAIT | pipeline frozen on data memory last cycle
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16,
    parameter int IMM_BIT      = 3
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

    opcode_t  id_op;
    reg_idx_t id_rd;
    reg_idx_t id_rs1;
    reg_idx_t id_rs2;

    shadow_t          ex_q;
    shadow_t          dm_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       fl_cnt_q;
    logic [1:0]       fl_cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic lu_haz;
    logic dm_req_c;
    logic mem_wait;
    logic pc_en_c;
    logic ifid_en_c;
    logic pipe_en_c;
    logic bubble_c;
    logic flush_c;
    logic unused_bits;

    assign id_op  = bus.ins[OP_HI:OP_LO];
    assign id_rd  = bus.ins[RD_HI:RD_LO];
    assign id_rs1 = bus.ins[RS1_HI:RS1_LO];
    assign id_rs2 = bus.ins[RS2_HI:RS2_LO];

    assign unused_bits = ^{bus.ins[RS2_LO-1:0], dm_q.rd};

    hazard_detect #(.IMM_BIT(IMM_BIT)) u_hazard_detect (
        .ex     (ex_q),
        .id_op  (id_op),
        .id_rs1 (id_rs1),
        .id_rs2 (id_rs2),
        .lu_haz (lu_haz)
    );

    assign dm_req_c = dm_q.v & is_mem_op(dm_q.op);
    assign mem_wait = dm_req_c & ~bus.dm_ready;

    always_comb begin
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        pipe_en_c = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        if (mem_wait) begin
            // A branch seen here is dropped; EX is frozen and re-presents it.
            state_d = ST_MEM_WAIT;
        end else if (bus.br_taken) begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            pipe_en_c = 1'b1;
            bubble_c  = 1'b1;
            flush_c   = 1'b1;
            fl_cnt_d  = FL_LOAD;
            state_d   = (FL_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
        end else if (fl_cnt_q != 2'd0) begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            pipe_en_c = 1'b1;
            bubble_c  = 1'b1;
            flush_c   = 1'b1;
            fl_cnt_d  = fl_cnt_q - 2'd1;
            state_d   = (fl_cnt_q != 2'd1) ? ST_FLUSH : ST_RUN;
        end else if (lu_haz) begin
            pipe_en_c = 1'b1;
            bubble_c  = 1'b1;
            state_d   = ST_STALL;
        end else begin
            pc_en_c   = 1'b1;
            ifid_en_c = 1'b1;
            pipe_en_c = 1'b1;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q     <= '0;
            dm_q     <= '0;
            state_q  <= ST_RUN;
            fl_cnt_q <= 2'd0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
            if (pipe_en_c) begin
                dm_q <= ex_q;
                ex_q <= {~bubble_c, id_op, id_rd};
            end
            if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    // Enables are forced low while reset is held, independent of any clock.
    assign bus.pc_en     = reset & pc_en_c;
    assign bus.ifid_en   = reset & ifid_en_c;
    assign bus.pipe_en   = reset & pipe_en_c;
    assign bus.bubble    = reset & bubble_c;
    assign bus.flush     = reset & flush_c;
    assign bus.dm_req    = reset & dm_req_c;
    assign bus.fsm_state = state_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline (IF, ID, EX, DM, WB); sits beside the forwarding/dependency logic.
- Tracks the ID→EX→DM instruction flow in shadow registers and detects load-use hazards.
- Squashes wrong-path instructions on taken branches and freezes the pipeline while data memory is not ready.
- Drives the PC, IF/ID and pipeline-register enables, bubble insertion and flush.

Parameters:
OP_LD, 6'b010100, load opcode
OP_ST, 6'b010101, store opcode
OP_BR, 6'b011100, conditional branch opcode
IMM_BIT, 3, opcode bit that marks immediate-form ALU ops (no rs2 read)
FLUSH_CYCLES, 1, squash cycles after a taken branch (1..3)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ins  in  32  instruction in ID; fields: op[31:26], rd[25:21], rs1[20:16], rs2[15:11]
br_taken  in  1  branch in EX resolved taken (single-cycle pulse)
dm_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register load enable
pipe_en  out  1  ID/EX, EX/DM, DM/WB register enable
bubble  out  1  load NOP into ID/EX instead of decoded ID instruction
flush  out  1  clear IF/ID to NOP
dm_req  out  1  memory access pending in DM stage
fsm_state  out  2  RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Interface rule: one clock, clk. Reset is asynchronous and active-low, port named reset.
- Shadow registers: ex_v/ex_op/ex_rd and dm_v/dm_op/dm_rd.
  - When pipe_en=1 they shift: ID→EX gets {!bubble, op, rd}, and EX→DM.
  - When pipe_en=0 they hold.
- Reset (reset=0):
  - Shadows invalid, fsm_state=RUN, flush counter 0, stall_cnt 0.
  - While reset is low: pc_en=ifid_en=pipe_en=0, bubble=flush=dm_req=0.
- uses_rs2 = (op==OP_ST) | (op==OP_BR) | (op!=OP_LD & !op[IMM_BIT]).
- Hazard and request terms:
  - lu_haz = ex_v & ex_op==OP_LD & (ex_rd==rs1 | (uses_rs2 & ex_rd==rs2)). r0 is not special.
  - dm_req = dm_v & (dm_op==OP_LD | dm_op==OP_ST).
- Outputs are combinational from current state, shadows and inputs. Priority, highest first:
  1. MEM_WAIT condition (dm_req & !dm_ready): pc_en=ifid_en=pipe_en=0, bubble=flush=0. A br_taken seen in the same cycle is ignored; the EX branch is held and re-presents br_taken after release.
  2. Taken branch (br_taken): pc_en=1, pipe_en=1, ifid_en=1, flush=1, bubble=1. Next state is FLUSH for FLUSH_CYCLES-1 further cycles, or RUN if FLUSH_CYCLES=1.
  3. FLUSH with counter nonzero: flush=1, bubble=1, pc_en=ifid_en=pipe_en=1; counter decrements.
  4. lu_haz: pc_en=ifid_en=0, pipe_en=1, bubble=1, for exactly one cycle. The bubble moves the load to DM, so lu_haz clears the next cycle.
  5. Otherwise RUN: pc_en=ifid_en=pipe_en=1, bubble=flush=0.
- fsm_state register:
  - Next value = MEM_WAIT / FLUSH / STALL / RUN per the winning case above.
  - A state-3 cycle in FLUSH keeps FLUSH until the counter reaches 0.
  - Reflects the action taken in the previous cycle.
- MEM_WAIT exit: the cycle dm_ready=1 arrives, the rows below it apply normally. Zero added latency; a same-cycle lu_haz is still honoured.
- A branch arriving during FLUSH restarts the counter.
- stall_cnt: increments each cycle pc_en=0 and reset is high; saturates at all-ones.
- Reset asserted mid-stall or mid-flush: immediate return to RUN with all counters cleared.

Decomposition:
- Package pipe_pkg: opcode constants (OP_LD, OP_ST, OP_BR), field bit positions, fsm_state encodings, NOP encoding.
- Sub-module hazard_detect: combinational uses_rs2 and lu_haz compare. Everything else stays in the top.

Test Plan:
1. Reset low 2 cycles with ins=000000_00001_00010_00011_0…: all outputs 0, stall_cnt=0. After release: pc_en=ifid_en=pipe_en=1, fsm_state=0.
2. Load-use on rs2:
   - Issue 010100_00100_00001_… (ld r4); next cycle ID holds 000100_00101_00001_00100 (uses r4 as rs2).
   - Expect exactly one cycle with pc_en=0, bubble=1, then RUN; stall_cnt=1.
   - Same with 001101_00110_00100_… (immediate form, r4 as rs1): stall. Same with r4 only in the rs2 field and op bit3=1: no stall.
3. Pulse br_taken with FLUSH_CYCLES=2: flush=bubble=1 for 2 consecutive cycles, fsm_state=2, pc_en stays 1.
4. Load in DM with dm_ready=0 for 3 cycles:
   - pc_en=ifid_en=pipe_en=0 for 3 cycles, fsm_state=3, stall_cnt +3.
   - br_taken held high during the wait produces flush only in the cycle dm_ready=1.
5. Assert reset low in the middle of MEM_WAIT: outputs drop to 0 asynchronously. After release: fsm_state=0, stall_cnt=0, shadows invalid (no spurious stall on the next dependent instruction).
6. Force 2^CNT_W+5 stall cycles via dm_ready=0: stall_cnt holds at all-ones.
